// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues one load/store at a time on the SRAM-like data bus and aligns load data.
// Optional define MEM_ALIGN_EXC_EN: misaligned half/word raises mem_adel/mem_ades instead of masking the address.
module mem_access_stage #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_valid,
  input  logic              ex_load,
  input  logic              ex_store,
  input  logic [1:0]        ex_size,
  input  logic              ex_sext,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [31:0]       ex_wdata,
  input  logic              flush,
  output logic              mem_stall,
  output logic              mem_done,
  output logic [31:0]       mem_rdata,
  output logic              mem_adel,
  output logic              mem_ades,
  output logic              mem_buserr,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [3:0]        data_wstrb,
  output logic [31:0]       data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [31:0]       data_rdata
);

  localparam int unsigned CNT_W   = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  localparam int unsigned TO_LAST = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DISCARD} state_t;

  state_t            state, state_nx;
  logic              op_wr, op_sext;
  logic [1:0]        op_size;
  logic [ADDR_W-1:0] op_addr;
  logic [3:0]        op_wstrb;
  logic [31:0]       op_wdata;
  logic [CNT_W-1:0]  wd_cnt;
  logic              done_q, buserr_q;
  logic [31:0]       rdata_q;

  logic              idle_take_c, start_c, adel_c, ades_c, timeout_c, resp_ok_c;
  logic [ADDR_W-1:0] cap_addr_c;
  logic [3:0]        cap_wstrb_c;
  logic [31:0]       cap_wdata_c, load_data_c;
  logic [7:0]        ld_byte_c;
  logic [15:0]       ld_half_c;

  // New-access decision; the done cycle is skipped because EX/MEM still holds the finished op
  always_comb begin
    idle_take_c = (state == S_IDLE) && !reset && !flush && !done_q && ex_valid;
    cap_addr_c  = ex_addr;
`ifdef MEM_ALIGN_EXC_EN
    begin
      logic misalign_c;
      misalign_c = (ex_size == 2'd1) ? ex_addr[0] : (ex_size[1] && (ex_addr[1:0] != 2'b00));
      start_c    = idle_take_c && (ex_load || ex_store) && !misalign_c;
      adel_c     = idle_take_c && ex_load && misalign_c;
      ades_c     = idle_take_c && ex_store && misalign_c;
    end
`else
    start_c = idle_take_c && (ex_load || ex_store);
    adel_c  = 1'b0;
    ades_c  = 1'b0;
    if (ex_size == 2'd1) begin
      cap_addr_c[0] = 1'b0;
    end else if (ex_size[1]) begin
      cap_addr_c[1:0] = 2'b00;
    end
`endif
  end

  // Store byte enables and lane-replicated data
  always_comb begin
    cap_wstrb_c = 4'b0000;
    cap_wdata_c = ex_wdata;
    case (ex_size)
      2'd0: begin
        cap_wstrb_c = 4'b0001 << cap_addr_c[1:0];
        cap_wdata_c = {4{ex_wdata[7:0]}};
      end
      2'd1: begin
        cap_wstrb_c = 4'b0011 << {cap_addr_c[1], 1'b0};
        cap_wdata_c = {2{ex_wdata[15:0]}};
      end
      default: cap_wstrb_c = 4'b1111;
    endcase
    if (!ex_store) begin
      cap_wstrb_c = 4'b0000;
    end
  end

  // Load lane selection and extension
  always_comb begin
    case (op_addr[1:0])
      2'd0:    ld_byte_c = data_rdata[7:0];
      2'd1:    ld_byte_c = data_rdata[15:8];
      2'd2:    ld_byte_c = data_rdata[23:16];
      default: ld_byte_c = data_rdata[31:24];
    endcase
    ld_half_c = op_addr[1] ? data_rdata[31:16] : data_rdata[15:0];
    case (op_size)
      2'd0:    load_data_c = op_sext ? {{24{ld_byte_c[7]}}, ld_byte_c} : {24'd0, ld_byte_c};
      2'd1:    load_data_c = op_sext ? {{16{ld_half_c[15]}}, ld_half_c} : {16'd0, ld_half_c};
      default: load_data_c = data_rdata;
    endcase
  end

  // Next state and bus/stall outputs
  always_comb begin
    state_nx   = state;
    timeout_c  = 1'b0;
    resp_ok_c  = 1'b0;
    mem_stall  = 1'b0;
    data_req   = 1'b0;
    data_wr    = 1'b0;
    data_size  = 2'b00;
    data_addr  = '0;
    data_wstrb = 4'b0000;
    data_wdata = 32'd0;
    case (state)
      S_IDLE: begin
        if (start_c) begin
          state_nx  = S_REQ;
          mem_stall = 1'b1;
        end
      end
      S_REQ: begin
        mem_stall  = 1'b1;
        data_req   = 1'b1;
        data_wr    = op_wr;
        data_size  = op_size;
        data_addr  = op_addr;
        data_wstrb = op_wstrb;
        data_wdata = op_wdata;
        if (data_addr_ok) begin
          state_nx = flush ? S_DISCARD : S_WAIT;
        end else if (flush) begin
          state_nx = S_IDLE;
        end
      end
      S_WAIT: begin
        mem_stall = 1'b1;
        if (data_data_ok) begin
          state_nx  = S_IDLE;
          resp_ok_c = !flush;
        end else if (flush) begin
          state_nx = S_DISCARD;
        end else if ((TIMEOUT != 0) && (wd_cnt == CNT_W'(TO_LAST))) begin
          state_nx  = S_DISCARD;
          timeout_c = 1'b1;
        end
      end
      S_DISCARD: begin
        mem_stall = 1'b1;
        if (data_data_ok) begin
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
    if (reset) begin
      mem_stall = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      op_wr    <= 1'b0;
      op_sext  <= 1'b0;
      op_size  <= 2'b00;
      op_addr  <= '0;
      op_wstrb <= 4'b0000;
      op_wdata <= 32'd0;
      wd_cnt   <= '0;
      done_q   <= 1'b0;
      buserr_q <= 1'b0;
      rdata_q  <= 32'd0;
    end else begin
      state    <= state_nx;
      done_q   <= resp_ok_c;
      buserr_q <= timeout_c;
      wd_cnt   <= (state == S_WAIT) ? wd_cnt + CNT_W'(1) : '0;
      if (start_c) begin
        op_wr    <= ex_store;
        op_sext  <= ex_sext;
        op_size  <= ex_size;
        op_addr  <= cap_addr_c;
        op_wstrb <= cap_wstrb_c;
        op_wdata <= cap_wdata_c;
      end
      if (resp_ok_c) begin
        rdata_q <= op_wr ? 32'd0 : load_data_c;
      end
    end
  end

  assign mem_done   = done_q;
  assign mem_rdata  = rdata_q;
  assign mem_buserr = buserr_q;
  assign mem_adel   = adel_c;
  assign mem_ades   = ades_c;

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized self-checking bench for mem_access_stage against an arithmetic reference model.
`timescale 1ns/1ps
module tb_mem_access_stage;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid, ex_load, ex_store, ex_sext, flush;
  logic [1:0]  ex_size;
  logic [31:0] ex_addr, ex_wdata;
  logic        mem_stall, mem_done, mem_adel, mem_ades, mem_buserr;
  logic [31:0] mem_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok, data_data_ok;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_access_stage #(.ADDR_W(32), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .ex_valid(ex_valid), .ex_load(ex_load), .ex_store(ex_store), .ex_size(ex_size),
    .ex_sext(ex_sext), .ex_addr(ex_addr), .ex_wdata(ex_wdata), .flush(flush),
    .mem_stall(mem_stall), .mem_done(mem_done), .mem_rdata(mem_rdata),
    .mem_adel(mem_adel), .mem_ades(mem_ades), .mem_buserr(mem_buserr),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wstrb(data_wstrb), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model: access width in bytes, natural alignment, lane arithmetic
  function automatic int unsigned nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_addr(input logic [31:0] a, input logic [1:0] sz);
    return a - (a % nbytes(sz));
  endfunction

  function automatic bit ref_misalign(input logic [31:0] a, input logic [1:0] sz);
    return (a % nbytes(sz)) != 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] rd, input logic [31:0] a,
                                           input logic [1:0] sz, input bit sx);
    int unsigned n = nbytes(sz);
    logic [31:0] v;
    if (n == 4) return rd;
    v = (rd >> (8 * (a % 4))) % (32'd1 << (8 * n));
    if (sx && (v >= (32'd1 << (8 * n - 1)))) v = v - (32'd1 << (8 * n));
    return v;
  endfunction

  function automatic logic [31:0] ref_wstrb(input logic [31:0] a, input logic [1:0] sz);
    int unsigned n = nbytes(sz);
    return ((32'd1 << n) - 32'd1) << (a % 4);
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [31:0] wd, input logic [1:0] sz);
    int unsigned n = nbytes(sz);
    if (n == 4) return wd;
    return (wd % (32'd1 << (8 * n))) * ((n == 1) ? 32'h0101_0101 : 32'h0001_0001);
  endfunction

  task automatic drive_op(input bit ld, input logic [1:0] sz, input bit sx,
                          input logic [31:0] addr, input logic [31:0] wd);
    ex_valid = 1'b1;
    ex_load  = ld;
    ex_store = !ld;
    ex_size  = sz;
    ex_sext  = sx;
    ex_addr  = addr;
    ex_wdata = wd;
  endtask

  // One access with a scripted slave: addr_ok a_dly cycles into REQ, data_ok d_dly cycles later
  task automatic access(input string nm, input bit ld, input logic [1:0] sz, input bit sx,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input int a_dly, input int d_dly, input logic [31:0] rd);
    logic [31:0] ea = ref_addr(addr, sz);
    bit stall_ok = 1'b1;
    bit req_ok   = 1'b1;
    int extra    = 0;
    @(negedge clk);
    drive_op(ld, sz, sx, addr, wd);
    flush = 1'b0;
    #1;
`ifdef MEM_ALIGN_EXC_EN
    if (ref_misalign(addr, sz)) begin
      check({nm, "/adel"}, 32'(mem_adel), 32'(ld));
      check({nm, "/ades"}, 32'(mem_ades), 32'(!ld));
      check({nm, "/exc_stall"}, 32'(mem_stall), 32'd0);
      @(negedge clk);
      ex_valid = 1'b0;
      #1;
      check({nm, "/exc_noreq"}, 32'(data_req), 32'd0);
      return;
    end
`endif
    check({nm, "/stall_cap"}, 32'(mem_stall), 32'd1);
    for (int c = 0; c <= a_dly + d_dly + 1; c++) begin
      @(negedge clk);
      data_addr_ok = (c == a_dly);
      data_data_ok = (c == a_dly + d_dly);
      data_rdata   = data_data_ok ? rd : $urandom;
      #1;
      if (c == a_dly) begin
        check({nm, "/req"},  32'(data_req),  32'd1);
        check({nm, "/wr"},   32'(data_wr),   32'(!ld));
        check({nm, "/size"}, 32'(data_size), 32'(sz));
        check({nm, "/addr"}, data_addr, ea);
        check({nm, "/wstrb"}, 32'(data_wstrb), ld ? 32'd0 : ref_wstrb(ea, sz));
        if (!ld) check({nm, "/wdata"}, data_wdata, ref_wdata(wd, sz));
      end else if ((c < a_dly) && (data_req !== 1'b1)) begin
        req_ok = 1'b0;
      end else if ((c > a_dly) && (data_req !== 1'b0)) begin
        req_ok = 1'b0;
      end
      if (c == a_dly + d_dly + 1) begin
        check({nm, "/done"}, 32'(mem_done), 32'd1);
        check({nm, "/stall_done"}, 32'(mem_stall), 32'd0);
        if (ld) check({nm, "/rdata"}, mem_rdata, ref_load(rd, ea, sz, sx));
      end else begin
        if (mem_stall !== 1'b1) stall_ok = 1'b0;
        if ((mem_done !== 1'b0) || (mem_buserr !== 1'b0)) extra++;
      end
    end
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    @(negedge clk);
    ex_valid = 1'b0;
    #1;
    check({nm, "/after"}, {29'd0, data_req, mem_done, mem_stall}, 32'd0);
    check({nm, "/stall_hold"}, 32'(stall_ok), 32'd1);
    check({nm, "/req_shape"}, 32'(req_ok), 32'd1);
    check({nm, "/spurious"}, 32'(extra), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    reset = 1'b1; ex_valid = 1'b0; ex_load = 1'b0; ex_store = 1'b0; ex_size = 2'd0;
    ex_sext = 1'b0; ex_addr = 32'd0; ex_wdata = 32'd0; flush = 1'b0;
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_ctrl", {19'd0, mem_stall, mem_done, mem_adel, mem_ades, mem_buserr, data_req,
                       data_wr, data_size, data_wstrb}, 32'd0);
    check("rst_rdata", mem_rdata, 32'd0);
    check("rst_addr", data_addr, 32'd0);

    // Non-memory instruction passes straight through
    @(negedge clk);
    ex_valid = 1'b1; ex_load = 1'b0; ex_store = 1'b0;
    #1;
    check("alu_stall", 32'(mem_stall), 32'd0);
    @(negedge clk);
    ex_valid = 1'b0;
    #1;
    check("alu_noreq", 32'(data_req), 32'd0);

    access("lb_sext", 1'b1, 2'd0, 1'b1, 32'h0000_1003, 32'd0, 0, 1, 32'h80FF_FF00);
    check("lb_sext_lit", mem_rdata, 32'hFFFF_FF80);
    access("sh", 1'b0, 2'd1, 1'b0, 32'h0000_2002, 32'h0000_ABCD, 0, 1, 32'd0);
    access("lw_slow", 1'b1, 2'd2, 1'b0, 32'h0000_4008, 32'd0, 2, 3, 32'hCAFE_F00D);
    access("lh_mis", 1'b1, 2'd1, 1'b1, 32'h0000_3001, 32'd0, 0, 1, 32'h1234_8765);
    access("lw_sz3", 1'b1, 2'd3, 1'b0, 32'h0000_5004, 32'd0, 1, 4, 32'h0BAD_BEEF);

    for (int i = 0; i < 40; i++) begin
      access("rnd", 1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom,
             int'($urandom_range(0, 3)), int'($urandom_range(1, 4)), $urandom);
    end

    // Flush in WAIT: response discarded, next load waits behind it
    @(negedge clk); drive_op(1'b1, 2'd2, 1'b0, 32'h0000_0040, 32'd0);
    @(negedge clk); data_addr_ok = 1'b1;
    @(negedge clk); data_addr_ok = 1'b0; flush = 1'b1; ex_addr = 32'h0000_0080;
    #1; check("fl_wait_stall", 32'(mem_stall), 32'd1);
    @(negedge clk); flush = 1'b0;
    #1; check("fl_disc_noreq", 32'(data_req), 32'd0);
    check("fl_disc_stall", 32'(mem_stall), 32'd1);
    @(negedge clk); data_data_ok = 1'b1; data_rdata = 32'hDEAD_BEEF;
    #1; check("fl_disc_stall2", 32'(mem_stall), 32'd1);
    @(negedge clk); data_data_ok = 1'b0;
    #1; check("fl_nodone", 32'(mem_done), 32'd0);
    check("fl_new_noreq", 32'(data_req), 32'd0);
    check("fl_new_stall", 32'(mem_stall), 32'd1);
    @(negedge clk); data_addr_ok = 1'b1;
    #1; check("fl_new_req", 32'(data_req), 32'd1);
    check("fl_new_addr", data_addr, 32'h0000_0080);
    @(negedge clk); data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h1234_5678;
    @(negedge clk); data_data_ok = 1'b0;
    #1; check("fl_new_done", 32'(mem_done), 32'd1);
    check("fl_new_rdata", mem_rdata, 32'h1234_5678);
    @(negedge clk); ex_valid = 1'b0;

    // Flush in REQ without addr_ok withdraws the request
    @(negedge clk); drive_op(1'b1, 2'd2, 1'b0, 32'h0000_0200, 32'd0);
    @(negedge clk); flush = 1'b1; ex_valid = 1'b0;
    #1; check("flreq_req", 32'(data_req), 32'd1);
    @(negedge clk); flush = 1'b0;
    #1; check("flreq_gone", {30'd0, data_req, mem_stall}, 32'd0);

    // Watchdog: data_ok withheld, buserr 4 cycles after WAIT entry, late data_ok dropped
    @(negedge clk); drive_op(1'b1, 2'd2, 1'b0, 32'h0000_0100, 32'd0);
    @(negedge clk); data_addr_ok = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      data_addr_ok = 1'b0;
      data_data_ok = (c == 7);
      if (c == 5) ex_valid = 1'b0;
      #1;
      if (c == 4) check("wd_early", 32'(mem_buserr), 32'd0);
      if (c == 5) begin
        check("wd_pulse", 32'(mem_buserr), 32'd1);
        check("wd_disc_stall", 32'(mem_stall), 32'd1);
      end
      if (c == 6) check("wd_once", 32'(mem_buserr), 32'd0);
      if (c == 7) check("wd_late_stall", 32'(mem_stall), 32'd1);
      if (c == 8) check("wd_late_drop", {29'd0, mem_done, mem_stall, data_req}, 32'd0);
    end
    data_data_ok = 1'b0;

    access("post_wd", 1'b1, 2'd0, 1'b0, 32'h0000_0102, 32'd0, 0, 1, 32'h00AB_0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
